// File: rtl/rot_pkg.sv
// rot_pkg: shared widths, direction encodings and requester IDs for the rot8 arbiter.
package rot_pkg;
    localparam int DATA_W = 8;
    localparam int AMT_W = 3;
    localparam logic DIR_LEFT = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/rot8_core.sv
// rot8_core: combinational 8-bit rotate left/right built from 1, 2 and 4 bit log stages.
module rot8_core
    import rot_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  move,
    input  logic              dir,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    // A 4-bit rotation is identical in both directions, so the last stage ignores dir.
    always_comb begin
        s1 = move[0] ? (dir == DIR_RIGHT ? {data[0], data[7:1]} : {data[6:0], data[7]}) : data;
        s2 = move[1] ? (dir == DIR_RIGHT ? {s1[1:0], s1[7:2]} : {s1[5:0], s1[7:6]}) : s1;
        result = move[2] ? {s2[3:0], s2[7:4]} : s2;
    end
endmodule

// File: rtl/rot8_arbiter.sv
// rot8_arbiter: round-robin share of one rot8_core between two requesters, with a
// registered tagged result port and per-requester completion counters.
module rot8_arbiter
    import rot_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_move,
    input  logic              req0_dir,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_move,
    input  logic              req1_dir,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_tag,
    input  logic              res_ready,
    output logic [7:0]        done0_cnt,
    output logic [7:0]        done1_cnt
);
    logic              last_grant;
    logic              can_issue;
    logic              grant0;
    logic              grant1;
    logic              fire;
    logic              drain;
    logic [DATA_W-1:0] op_data;
    logic [AMT_W-1:0]  op_move;
    logic              op_dir;
    logic [DATA_W-1:0] rot_result;

    // Readys are forced low while reset is held so nothing is accepted into a clearing register.
    always_comb begin
        can_issue = !res_valid || res_ready;
        grant0 = req0_valid && (!req1_valid || last_grant == ID_REQ1);
        grant1 = req1_valid && !grant0;
        req0_ready = !reset && can_issue && grant0;
        req1_ready = !reset && can_issue && grant1;
        fire = req0_ready || req1_ready;
        drain = res_valid && res_ready;
        op_data = grant0 ? req0_data : req1_data;
        op_move = grant0 ? req0_move : req1_move;
        op_dir = grant0 ? req0_dir : req1_dir;
    end

    rot8_core u_core (
        .data   (op_data),
        .move   (op_move),
        .dir    (op_dir),
        .result (rot_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data <= '0;
            res_tag <= ID_REQ0;
            last_grant <= ID_REQ1;
            done0_cnt <= '0;
            done1_cnt <= '0;
        end else begin
            if (drain && res_tag == ID_REQ0) done0_cnt <= done0_cnt + 8'd1;
            if (drain && res_tag == ID_REQ1) done1_cnt <= done1_cnt + 8'd1;
            if (fire) begin
                res_valid <= 1'b1;
                res_data <= rot_result;
                res_tag <= grant0 ? ID_REQ0 : ID_REQ1;
                last_grant <= grant0 ? ID_REQ0 : ID_REQ1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rot8_arbiter.sv
// tb_rot8_arbiter: table vectors, directed corner sequences and random traffic
// checked against a behavioural model of the rot8 arbiter.
module tb_rot8_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic [2:0] req0_move = '0, req1_move = '0;
    logic       req0_dir = 1'b0, req1_dir = 1'b0;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_tag;
    logic [7:0] res_data;
    logic       res_ready = 1'b0;
    logic [7:0] done0_cnt, done1_cnt;

    int total = 0;
    int bad = 0;
    int m_valid, m_data, m_tag, m_last;
    int m_cnt[2];

    typedef struct {
        int data;
        int move;
        int dir;
        int exp;
    } vec_t;
    vec_t tbl[8];

    rot8_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_move  (req0_move),
        .req0_dir   (req0_dir),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_move  (req1_move),
        .req1_dir   (req1_dir),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_ready  (res_ready),
        .done0_cnt  (done0_cnt),
        .done1_cnt  (done1_cnt)
    );

    always #5 clk = ~clk;

    // Right rotation by m equals left rotation by (8-m) mod 8.
    function automatic int rot(int d, int m, int dir);
        int s;
        s = dir ? (8 - m) % 8 : m;
        return ((d << s) | (d >> (8 - s))) & 255;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data = 0;
        m_tag = 0;
        m_last = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // Called just after a rising edge with inputs already driven; returns the granted ID or -1.
    task automatic cyc(output int g);
        int can, g0, g1;
        #1;
        can = (!m_valid || res_ready) ? 1 : 0;
        g0 = (can && req0_valid && (!req1_valid || m_last == 1)) ? 1 : 0;
        g1 = (can && req1_valid && (!req0_valid || m_last == 0)) ? 1 : 0;
        chk("ready0", int'(req0_ready), g0);
        chk("ready1", int'(req1_ready), g1);
        @(posedge clk);
        if (m_valid && res_ready) m_cnt[m_tag] = (m_cnt[m_tag] + 1) % 256;
        if (g0) begin
            m_data = rot(req0_data, req0_move, req0_dir);
            m_tag = 0;
            m_valid = 1;
            m_last = 0;
        end else if (g1) begin
            m_data = rot(req1_data, req1_move, req1_dir);
            m_tag = 1;
            m_valid = 1;
            m_last = 1;
        end else if (res_ready) begin
            m_valid = 0;
        end
        g = g0 ? 0 : (g1 ? 1 : -1);
        #1;
        chk("res_valid", int'(res_valid), m_valid);
        chk("res_data", int'(res_data), m_data);
        chk("res_tag", int'(res_tag), m_tag);
        chk("done0_cnt", int'(done0_cnt), m_cnt[0]);
        chk("done1_cnt", int'(done1_cnt), m_cnt[1]);
    endtask

    task automatic set_req(int id, int v, int d, int m, int dir);
        if (id == 0) begin
            req0_valid = v[0]; req0_data = d[7:0]; req0_move = m[2:0]; req0_dir = dir[0];
        end else begin
            req1_valid = v[0]; req1_data = d[7:0]; req1_move = m[2:0]; req1_dir = dir[0];
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int g;
        tbl[0] = '{'hB4, 3, 0, 'hA5};
        tbl[1] = '{'h01, 1, 1, 'h80};
        tbl[2] = '{'h81, 7, 0, 'hC0};
        tbl[3] = '{'h3C, 0, 1, 'h3C};
        tbl[4] = '{'h12, 4, 0, 'h21};
        tbl[5] = '{'h12, 4, 1, 'h21};
        tbl[6] = '{'h80, 1, 0, 'h01};
        tbl[7] = '{'hF0, 2, 1, 'h3C};
        model_reset();

        // Reset state, and readys held low while reset is asserted.
        repeat (2) @(posedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_data", int'(res_data), 0);
        chk("rst_tag", int'(res_tag), 0);
        chk("rst_cnt0", int'(done0_cnt), 0);
        chk("rst_cnt1", int'(done1_cnt), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // First issue and drain.
        set_req(0, 1, 'hB4, 3, 0);
        cyc(g);
        chk("t1_data", int'(res_data), 'hA5);
        chk("t1_tag", int'(res_tag), 0);
        set_req(0, 0, 0, 0, 0);
        res_ready = 1'b1;
        cyc(g);
        chk("t1_cnt0", int'(done0_cnt), 1);
        chk("t1_empty", int'(res_valid), 0);

        // Requester 1 sequence with res_ready high.
        set_req(1, 1, 'h01, 1, 1);
        cyc(g);
        chk("t2a_data", int'(res_data), 'h80);
        chk("t2a_tag", int'(res_tag), 1);
        set_req(1, 1, 'h81, 7, 0);
        cyc(g);
        chk("t2b_data", int'(res_data), 'hC0);
        set_req(1, 1, 'h5A, 0, 1);
        cyc(g);
        chk("t2c_data", int'(res_data), 'h5A);
        set_req(1, 0, 0, 0, 0);

        // Rotation table, alternating requesters.
        for (int i = 0; i < 8; i++) begin
            set_req(i % 2, 1, tbl[i].data, tbl[i].move, tbl[i].dir);
            set_req(1 - i % 2, 0, 0, 0, 0);
            cyc(g);
            chk($sformatf("tbl%0d_data", i), int'(res_data), tbl[i].exp);
            chk($sformatf("tbl%0d_tag", i), int'(res_tag), i % 2);
        end

        // Contention: last grant was requester 1, so grants go 0,1,0,1.
        set_req(0, 1, 'h11, 1, 0);
        set_req(1, 1, 'h22, 2, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(g);
            chk($sformatf("alt%0d_grant", i), g, i % 2);
            chk($sformatf("alt%0d_tag", i), int'(res_tag), i % 2);
        end

        // Back-pressure: FULL with res_ready low stalls both requesters.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(g);
            chk($sformatf("bp%0d_grant", i), g, -1);
        end
        res_ready = 1'b1;
        cyc(g);
        chk("bp_release_valid", int'(res_valid), 1);
        chk("bp_release_grant", g, 0);

        // Asynchronous reset while FULL and stalled.
        res_ready = 1'b0;
        cyc(g);
        #1 reset = 1'b1;
        #2;
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_cnt0", int'(done0_cnt), 0);
        chk("arst_cnt1", int'(done1_cnt), 0);
        chk("arst_ready0", int'(req0_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        res_ready = 1'b1;
        cyc(g);
        chk("arst_first_grant", g, 0);
        chk("arst_first_tag", int'(res_tag), 0);

        // 256 results for requester 0 wrap its counter back to 0.
        set_req(1, 0, 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            set_req(0, 1, $urandom_range(255), $urandom_range(7), $urandom_range(1));
            cyc(g);
        end
        set_req(0, 0, 0, 0, 0);
        cyc(g);
        chk("wrap_cnt0", int'(done0_cnt), 0);
        chk("wrap_cnt1", int'(done1_cnt), 0);

        // Random traffic; a stalled requester holds its command.
        for (int i = 0; i < 400; i++) begin
            if (!(req0_valid && g != 0)) set_req(0, $urandom_range(1), $urandom_range(255), $urandom_range(7), $urandom_range(1));
            if (!(req1_valid && g != 1)) set_req(1, $urandom_range(1), $urandom_range(255), $urandom_range(7), $urandom_range(1));
            res_ready = ($urandom_range(3) != 0);
            cyc(g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
